// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Optional tick outputs are enabled by defining CLKDIV_TICK_EN.
package clkdiv_pkg;

    localparam int unsigned DEFAULT_HALF_1HZ = 50000000;
    localparam int unsigned HALF_10HZ        = 5000000;
    localparam int unsigned HALF_1KHZ        = 50000;

    // Channel index width; a single-channel build still needs one select bit.
    function automatic int CH_IDX_W(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active and pending half-period, output toggle.
// Tick register exists only when CLKDIV_TICK_EN is defined.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int          CNT_WIDTH    = 26,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_1HZ
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 enable_i,
    input  logic                 restart_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_half_i,
    output logic                 clk_o,
`ifdef CLKDIV_TICK_EN
    output logic                 tick_o,
`endif
    output logic                 pending_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] half_q, half_d;
    logic [CNT_WIDTH-1:0] phalf_q, phalf_d;
    logic                 pending_q, pending_d;
    logic                 out_q, out_d;
    logic                 toggle;
    logic [CNT_WIDTH-1:0] terminal;
    logic                 at_term;

    // A half-period of 0 behaves as 1 so the channel runs at Fclk/2.
    assign terminal = (half_q == '0) ? '0 : half_q - CNT_WIDTH'(1);
    assign at_term  = enable_i && (cnt_q == terminal);

    always_comb begin
        cnt_d     = cnt_q;
        half_d    = half_q;
        phalf_d   = phalf_q;
        pending_d = pending_q;
        out_d     = out_q;
        toggle    = 1'b0;
        if (restart_i) begin
            cnt_d     = '0;
            out_d     = 1'b0;
            pending_d = 1'b0;
            if (pending_q) half_d = phalf_q;
        end else begin
            if (!enable_i) begin
                cnt_d = '0;
            end else if (at_term) begin
                cnt_d  = '0;
                out_d  = ~out_q;
                toggle = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            if ((!enable_i || at_term) && pending_q) begin
                half_d    = phalf_q;
                pending_d = 1'b0;
            end
            // A write landing on a terminal stays pending until the next one.
            if (load_i) begin
                phalf_d   = load_half_i;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q     <= '0;
            half_q    <= CNT_WIDTH'(DEFAULT_HALF);
            phalf_q   <= CNT_WIDTH'(DEFAULT_HALF);
            pending_q <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            phalf_q   <= phalf_d;
            pending_q <= pending_d;
            out_q     <= out_d;
        end
    end

`ifdef CLKDIV_TICK_EN
    logic tick_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) tick_q <= 1'b0;
        else        tick_q <= toggle;
    end

    assign tick_o = tick_q;
`else
    logic unused_toggle;
    assign unused_toggle = toggle;
`endif

    assign clk_o     = out_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// NUM_CH runtime-programmable square-wave dividers off the 100 MHz clock.
// Define CLKDIV_TICK_EN to add the per-channel Tick output.
module multi_channel_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_WIDTH    = 26,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_1HZ
) (
    input  logic                          Clock_100MHz,
    input  logic                          Clear,
    input  logic [NUM_CH-1:0]             Enable,
    input  logic                          Restart,
    input  logic                          Load,
    input  logic [CH_IDX_W(NUM_CH)-1:0]   Load_channel,
    input  logic [CNT_WIDTH-1:0]          Load_half,
    output logic [NUM_CH-1:0]             Clock_out,
`ifdef CLKDIV_TICK_EN
    output logic [NUM_CH-1:0]             Tick,
`endif
    output logic [NUM_CH-1:0]             Pending
);

    localparam int IDX_W = CH_IDX_W(NUM_CH);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // Indices at or above NUM_CH match no channel, so such writes vanish.
        localparam logic [IDX_W-1:0] CH_SEL = IDX_W'(gi);

        logic load_we;
        assign load_we = Load && (Load_channel == CH_SEL);

        clkdiv_channel #(
            .CNT_WIDTH    (CNT_WIDTH),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_channel (
            .clk_i       (Clock_100MHz),
            .srst_i      (Clear),
            .enable_i    (Enable[gi]),
            .restart_i   (Restart),
            .load_i      (load_we),
            .load_half_i (Load_half),
            .clk_o       (Clock_out[gi]),
`ifdef CLKDIV_TICK_EN
            .tick_o      (Tick[gi]),
`endif
            .pending_o   (Pending[gi])
        );
    end

endmodule
